// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin sharing of the single-port data RAM between the LSU (m0) and a second master (m1)
module lsu_mem_arbiter #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int DATA_ADDR_WIDTH = 16,
    parameter bit M0_HOLD_EN      = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_req_i,
    output logic                          m0_gnt_o,
    output logic                          m0_rvalid_o,
    input  logic [31:0]                   m0_addr_i,
    input  logic                          m0_we_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [AXI_DATA_WIDTH-1:0]     m0_wdata_i,
    output logic [AXI_DATA_WIDTH-1:0]     m0_rdata_o,
    input  logic                          m0_hold_i,
    input  logic                          m1_req_i,
    output logic                          m1_gnt_o,
    output logic                          m1_rvalid_o,
    input  logic [31:0]                   m1_addr_i,
    input  logic                          m1_we_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [AXI_DATA_WIDTH-1:0]     m1_wdata_i,
    output logic [AXI_DATA_WIDTH-1:0]     m1_rdata_o,
    output logic                          mem_en_o,
    output logic [DATA_ADDR_WIDTH-1:0]    mem_addr_o,
    output logic                          mem_we_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [AXI_DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                          busy_o
);
    logic last_q, owner_q, pend_q;
    logic elig0, elig1;

    // last_q/owner_q: 0 = m0, 1 = m1
    always_comb begin
        elig0       = m0_req_i && !(M0_HOLD_EN && m0_hold_i);
        elig1       = m1_req_i;
        m0_gnt_o    = !rst && elig0 && (!elig1 || last_q);
        m1_gnt_o    = !rst && elig1 && (!elig0 || !last_q);
        mem_en_o    = m0_gnt_o || m1_gnt_o;
        mem_addr_o  = m1_gnt_o ? m1_addr_i[DATA_ADDR_WIDTH-1:0] : m0_addr_i[DATA_ADDR_WIDTH-1:0];
        mem_we_o    = mem_en_o && (m1_gnt_o ? m1_we_i : m0_we_i);
        mem_be_o    = m1_gnt_o ? m1_be_i : m0_be_i;
        mem_wdata_o = m1_gnt_o ? m1_wdata_i : m0_wdata_i;
        m0_rdata_o  = mem_rdata_i;
        m1_rdata_o  = mem_rdata_i;
        // a response pending when reset arrives is dropped immediately
        m0_rvalid_o = !rst && pend_q && !owner_q;
        m1_rvalid_o = !rst && pend_q && owner_q;
        busy_o      = !rst && pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            pend_q  <= 1'b0;
        end else if (mem_en_o) begin
            last_q  <= m1_gnt_o;
            owner_q <= m1_gnt_o;
            pend_q  <= 1'b1;
        end else begin
            pend_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed vector table plus hand sequences against a behavioural RAM
module tb_lsu_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_gnt_o, m0_rvalid_o, m0_we_i, m0_hold_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic [3:0]  m0_be_i;
    logic        m1_req_i, m1_gnt_o, m1_rvalid_o, m1_we_i;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [3:0]  m1_be_i;
    logic        mem_en_o, mem_we_o, busy_o;
    logic [15:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [31:0] ram [0:255];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_hold_i(m0_hold_i),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    // single-port RAM with one-cycle read latency and byte-enabled writes
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end else begin
                mem_rdata_i <= ram[mem_addr_o[9:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst, req0, hold, req1;
        logic gnt0, gnt1, rv0, rv1, busy;
    } vec_t;

    vec_t tbl [20];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        mem_rdata_i = 32'h0;
        rst = 1'b1;
        m0_req_i = 0; m0_we_i = 0; m0_hold_i = 0; m0_be_i = 4'hF;
        m0_addr_i = 32'h0000_0010; m0_wdata_i = 32'h0;
        m1_req_i = 0; m1_we_i = 0; m1_be_i = 4'hF;
        m1_addr_i = 32'h0000_0020; m1_wdata_i = 32'h0;
        //          rst r0 hd r1   g0 g1 v0 v1 busy
        tbl[0]  = '{1, 1, 0, 1,   0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1,   1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1,   0, 1, 1, 0, 1};
        tbl[3]  = '{0, 1, 0, 1,   1, 0, 0, 1, 1};
        tbl[4]  = '{0, 1, 0, 1,   0, 1, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 1,   1, 0, 0, 1, 1};
        tbl[6]  = '{0, 1, 0, 1,   0, 1, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 0,   0, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 1,   0, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 1,   0, 1, 0, 1, 1};
        tbl[11] = '{0, 1, 1, 1,   0, 1, 0, 1, 1};
        tbl[12] = '{0, 1, 0, 1,   1, 0, 0, 1, 1};
        tbl[13] = '{0, 1, 0, 1,   0, 1, 1, 0, 1};
        tbl[14] = '{0, 1, 1, 0,   0, 0, 0, 1, 1};
        tbl[15] = '{0, 1, 0, 0,   1, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 1,   0, 1, 1, 0, 1};
        tbl[17] = '{1, 1, 0, 1,   0, 0, 0, 0, 0};
        tbl[18] = '{1, 1, 0, 1,   0, 0, 0, 0, 0};
        tbl[19] = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
        for (int i = 0; i < 20; i++) begin
            step();
            rst = tbl[i].rst; m0_req_i = tbl[i].req0; m0_hold_i = tbl[i].hold; m1_req_i = tbl[i].req1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), 32'(m0_gnt_o), 32'(tbl[i].gnt0));
            chk($sformatf("v%0d_gnt1", i), 32'(m1_gnt_o), 32'(tbl[i].gnt1));
            chk($sformatf("v%0d_rv0", i), 32'(m0_rvalid_o), 32'(tbl[i].rv0));
            chk($sformatf("v%0d_rv1", i), 32'(m1_rvalid_o), 32'(tbl[i].rv1));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
            chk($sformatf("v%0d_en", i), 32'(mem_en_o), 32'(tbl[i].gnt0 | tbl[i].gnt1));
            if (tbl[i].gnt0 | tbl[i].gnt1)
                chk($sformatf("v%0d_addr", i), 32'(mem_addr_o), tbl[i].gnt1 ? 32'h20 : 32'h10);
        end

        // single read from m0
        ram[8'h10] = 32'hDEADBEEF;
        step();
        m0_req_i = 1; m0_addr_i = 32'h0000_0040; m0_we_i = 0;
        @(negedge clk);
        chk("rd_gnt0", 32'(m0_gnt_o), 32'h1);
        chk("rd_addr", 32'(mem_addr_o), 32'h0040);
        chk("rd_we", 32'(mem_we_o), 32'h0);
        step();
        m0_req_i = 0;
        @(negedge clk);
        chk("rd_rv0", 32'(m0_rvalid_o), 32'h1);
        chk("rd_rv1", 32'(m1_rvalid_o), 32'h0);
        chk("rd_data", m0_rdata_o, 32'hDEADBEEF);

        // partial write by m1, read back by m0
        ram[8'h40] = 32'hAAAAAAAA;
        step();
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h0000_0100; m1_be_i = 4'b0011; m1_wdata_i = 32'h12345678;
        @(negedge clk);
        chk("wr_gnt1", 32'(m1_gnt_o), 32'h1);
        chk("wr_we", 32'(mem_we_o), 32'h1);
        chk("wr_be", 32'(mem_be_o), 32'h3);
        step();
        m1_req_i = 0; m1_we_i = 0;
        m0_req_i = 1; m0_addr_i = 32'h0000_0100;
        @(negedge clk);
        chk("wb_gnt0", 32'(m0_gnt_o), 32'h1);
        chk("wb_rv1", 32'(m1_rvalid_o), 32'h1);
        chk("wb_rv0", 32'(m0_rvalid_o), 32'h0);
        step();
        m0_req_i = 0;
        @(negedge clk);
        chk("wb_rv0_data", 32'(m0_rvalid_o), 32'h1);
        chk("wb_data", m0_rdata_o, 32'hAAAA5678);
        step();
        @(negedge clk);
        chk("idle_busy", 32'(busy_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
